// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - board timing constants and debounce helpers shared by the input conditioner
package input_conditioner_pkg;

  // Board-level constants: 12 MHz system clock, 10 ms debounce, 8 slide switches plus one toggle
  localparam int CLK_HZ      = 12000000;
  localparam int DEBOUNCE_MS = 10;
  localparam int SW_WIDTH    = 9;

  // Stable cycles needed before a new switch level is believed
  localparam int STABLE_CYCLES_DEFAULT = CLK_HZ / 1000 * DEBOUNCE_MS;

  // Counter width; the counter only needs to reach STABLE_CYCLES-1
  function automatic int cnt_width(input int stable_cycles);
    return (stable_cycles < 2) ? 1 : $clog2(stable_cycles);
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one switch bit: 2-flop synchroniser, stability counter, clean level and edge pulses
module debounce_bit
  import input_conditioner_pkg::*;
#(
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall,
  output logic settle
);

  localparam int             CW      = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  // High in the cycle whose edge will flip clean; the parent uses it to capture the snapshot on the same edge
  assign settle = (s2 != clean) && (cnt == CNT_MAX);

  // Two-flop synchroniser for the asynchronous switch level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Stability counter: any sample matching clean restarts the count, so short glitches never land
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      clean <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= settle && s2;
      fall <= settle && !s2;
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end else begin
        clean <= s2;
        cnt   <= '0;
      end
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounced switch levels, edge pulses and a valid/ready snapshot of each settled change
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH         = SW_WIDTH,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] clean,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic [WIDTH-1:0] snap_data,
  output logic             snap_valid,
  input  logic             snap_ready,
  output logic             overrun
);

  logic [WIDTH-1:0] settle;
  logic             any_settle;
  logic [WIDTH-1:0] next_clean;
  logic             accept;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_bit (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[i]),
      .clean (clean[i]),
      .rise  (rise[i]),
      .fall  (fall[i]),
      .settle(settle[i])
    );
  end

  // Settling bits flip, so the level clean will hold after this edge is a simple XOR
  assign any_settle = |settle;
  assign next_clean = clean ^ settle;
  assign accept     = snap_valid && snap_ready;

  // Change pulse and snapshot slot; a fresh change always wins the slot, an unread slot being overwritten flags overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      changed    <= 1'b0;
      snap_data  <= '0;
      snap_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      changed <= any_settle;
      if (any_settle) begin
        snap_data  <= next_clean;
        snap_valid <= 1'b1;
        if (snap_valid && !snap_ready) begin
          overrun <= 1'b1;
        end else if (accept) begin
          overrun <= 1'b0;
        end
      end else if (accept) begin
        snap_valid <= 1'b0;
        overrun    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - randomized and directed self-checking bench for input_conditioner
module tb_input_conditioner;

  localparam int W  = 9;
  localparam int SC = 4;

  logic         clk        = 1'b0;
  logic         rst_n      = 1'b0;
  logic [W-1:0] raw        = '0;
  logic         snap_ready = 1'b0;
  logic [W-1:0] clean;
  logic [W-1:0] rise;
  logic [W-1:0] fall;
  logic         changed;
  logic [W-1:0] snap_data;
  logic         snap_valid;
  logic         overrun;

  int total = 0;
  int bad   = 0;

  input_conditioner #(
    .WIDTH(W),
    .STABLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw       (raw),
    .clean     (clean),
    .rise      (rise),
    .fall      (fall),
    .changed   (changed),
    .snap_data (snap_data),
    .snap_valid(snap_valid),
    .snap_ready(snap_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Reference model: a bit settles when the last SC synchronised samples all disagree with its clean level.
  // hist[j] is the raw value sampled j+1 edges ago; the synchroniser delays by one more, so the window is hist[1..SC].
  logic [W-1:0] hist [0:SC];
  logic [W-1:0] m_clean = '0, m_rise = '0, m_fall = '0, m_sd = '0;
  logic         m_changed = 1'b0, m_sv = 1'b0, m_ov = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] flip;
    logic [W-1:0] nc;
    if (!rst_n) begin
      for (int j = 0; j <= SC; j++) hist[j] = '0;
      m_clean = '0; m_rise = '0; m_fall = '0; m_changed = 1'b0;
      m_sd = '0; m_sv = 1'b0; m_ov = 1'b0;
    end else begin
      flip = '1;
      for (int j = 1; j <= SC; j++) flip &= hist[j] ^ m_clean;
      nc        = m_clean ^ flip;
      m_rise    = flip & nc;
      m_fall    = flip & ~nc;
      m_changed = (flip != '0);
      if (m_changed) begin
        if (m_sv && !snap_ready) m_ov = 1'b1;
        else if (m_sv && snap_ready) m_ov = 1'b0;
        m_sd = nc;
        m_sv = 1'b1;
      end else if (m_sv && snap_ready) begin
        m_sv = 1'b0;
        m_ov = 1'b0;
      end
      m_clean = nc;
      for (int j = SC; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = raw;
    end
  end

  wire [4*W+2:0] obs = {clean, rise, fall, changed, snap_data, snap_valid, overrun};
  wire [4*W+2:0] mdl = {m_clean, m_rise, m_fall, m_changed, m_sd, m_sv, m_ov};

  task automatic test_reset();
    rst_n = 1'b0; raw = '0; snap_ready = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_outputs got=%h want=0", obs); end
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (obs !== '0) begin bad++; $display("FAIL reset_release got=%h want=0", obs); end
  endtask

  task automatic test_rise();
    logic [4*W+1:0] want;
    raw = 9'h0A5;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      want = {(n >= 5) ? 9'h0A5 : 9'h000, (n == 5) ? 9'h0A5 : 9'h000, 9'h000,
              (n == 5), (n >= 5) ? 9'h0A5 : 9'h000, (n >= 5)};
      total++;
      if (obs[4*W+2:1] !== want) begin bad++; $display("FAIL rise_a5 n=%0d got=%h want=%h", n, obs[4*W+2:1], want); end
      total++;
      if (obs !== mdl) begin bad++; $display("FAIL rise_model n=%0d got=%h want=%h", n, obs, mdl); end
    end
  endtask

  task automatic test_glitch();
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    total++;
    if ({snap_valid, overrun} !== 2'b00) begin bad++; $display("FAIL glitch_accept got=%b want=00", {snap_valid, overrun}); end
    raw = 9'h0AD;
    for (int n = 0; n < 11; n++) begin
      if (n == 3) raw = 9'h0A5;
      @(negedge clk);
      total++;
      if ({clean, rise, changed, snap_valid} !== {9'h0A5, 9'h000, 1'b0, 1'b0}) begin
        bad++; $display("FAIL glitch_hold n=%0d clean=%h rise=%h changed=%b valid=%b", n, clean, rise, changed, snap_valid);
      end
      total++;
      if (obs !== mdl) begin bad++; $display("FAIL glitch_model n=%0d got=%h want=%h", n, obs, mdl); end
    end
  endtask

  task automatic test_overrun();
    raw = 9'h001;
    repeat (8) @(negedge clk);
    total++;
    if ({snap_valid, snap_data, overrun} !== {1'b1, 9'h001, 1'b0}) begin
      bad++; $display("FAIL overrun_pending valid=%b data=%h ovr=%b want 1/001/0", snap_valid, snap_data, overrun);
    end
    raw = 9'h003;
    repeat (8) @(negedge clk);
    total++;
    if ({snap_valid, snap_data, overrun} !== {1'b1, 9'h003, 1'b1}) begin
      bad++; $display("FAIL overrun_set valid=%b data=%h ovr=%b want 1/003/1", snap_valid, snap_data, overrun);
    end
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    total++;
    if ({snap_valid, overrun} !== 2'b00) begin bad++; $display("FAIL overrun_clear got=%b want=00", {snap_valid, overrun}); end
    @(negedge clk);
    total++;
    if (obs !== mdl) begin bad++; $display("FAIL overrun_model got=%h want=%h", obs, mdl); end
  endtask

  task automatic test_back_to_back();
    raw = 9'h002;
    repeat (8) @(negedge clk);
    total++;
    if ({snap_valid, snap_data} !== {1'b1, 9'h002}) begin bad++; $display("FAIL b2b_pending valid=%b data=%h want 1/002", snap_valid, snap_data); end
    raw = 9'h100;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      snap_ready = (n == 4);
    end
    total++;
    if ({snap_valid, snap_data, overrun, changed} !== {1'b1, 9'h100, 1'b0, 1'b1}) begin
      bad++; $display("FAIL b2b_accept valid=%b data=%h ovr=%b chg=%b want 1/100/0/1", snap_valid, snap_data, overrun, changed);
    end
    total++;
    if (obs !== mdl) begin bad++; $display("FAIL b2b_model got=%h want=%h", obs, mdl); end
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    total++;
    if (snap_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b want=0", snap_valid); end
  endtask

  task automatic test_mid_reset();
    raw = 9'h1FF;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    total++;
    if (obs !== '0) begin bad++; $display("FAIL midreset_zero got=%h want=0", obs); end
    for (int m = 1; m <= 6; m++) begin
      @(negedge clk);
      total++;
      if ({clean, rise, changed} !== {(m == 6) ? 9'h1FF : 9'h000, (m == 6) ? 9'h1FF : 9'h000, (m == 6)}) begin
        bad++; $display("FAIL midreset_settle m=%0d clean=%h rise=%h chg=%b", m, clean, rise, changed);
      end
      total++;
      if (obs !== mdl) begin bad++; $display("FAIL midreset_model m=%0d got=%h want=%h", m, obs, mdl); end
    end
  endtask

  task automatic test_release();
    snap_ready = 1'b1;
    @(negedge clk);
    snap_ready = 1'b0;
    raw = 9'h0FF;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      total++;
      if ({fall, rise, changed} !== {(n == 5) ? 9'h100 : 9'h000, 9'h000, (n == 5)}) begin
        bad++; $display("FAIL release n=%0d fall=%h rise=%h chg=%b", n, fall, rise, changed);
      end
    end
    total++;
    if (clean !== 9'h0FF) begin bad++; $display("FAIL release_clean got=%h want=0ff", clean); end
  endtask

  task automatic test_random();
    int hold;
    for (int blk = 0; blk < 120; blk++) begin
      raw  = W'($urandom);
      hold = $urandom_range(1, 8);
      for (int c = 0; c < hold; c++) begin
        snap_ready = ($urandom_range(0, 3) == 0);
        rst_n      = ($urandom_range(0, 149) != 0);
        @(negedge clk);
        total++;
        if (obs !== mdl) begin bad++; $display("FAIL random blk=%0d c=%0d got=%h want=%h", blk, c, obs, mdl); end
      end
    end
    rst_n = 1'b1;
    snap_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise();
    test_glitch();
    test_overrun();
    test_back_to_back();
    test_mid_reset();
    test_release();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
